// File: rtl/aes_pkg.sv
// Shared AES constants and the InvSubBytes sequencer state encoding.
package aes_pkg;

    localparam int unsigned AES_NB_BYTES = 16;
    localparam int unsigned AES_BYTE_W   = 8;
    localparam int unsigned AES_STATE_W  = 128;

    typedef logic [AES_STATE_W-1:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box ROM with a 1-cycle registered read; no reset on the output register.
module inv_sbox (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] dout
);

    localparam logic [0:255][7:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [7:0] dout_q;

    always_ff @(posedge clk) begin
        dout_q <= INV_SBOX_TBL[addr];
    end

    assign dout = dout_q;

endmodule

// File: rtl/inv_subbytes_seq.sv
// InvSubBytes over a 128-bit state using LANES shared inv_sbox ROMs, 16/LANES issue cycles per block.
// Optional completed-block counter port blk_cnt when INV_SUBBYTES_SEQ_STATS_EN is defined.
module inv_subbytes_seq
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data
`ifdef INV_SUBBYTES_SEQ_STATS_EN
    ,
    output logic [31:0]            blk_cnt
`endif
);

    localparam int unsigned N         = AES_NB_BYTES / LANES;
    localparam int unsigned IDX_W     = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SRC_SHIFT = (N > 1) ? LANES * AES_BYTE_W : 0;

    seq_state_e             state_q, state_d;
    logic [IDX_W-1:0]       k_q, k_d;
    logic [IDX_W-1:0]       kd_q, kd_d;
    logic                   pv_q, pv_d;
    aes_state_t             src_q, src_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [LANES*AES_BYTE_W-1:0] rom_dout;

    // Source register shifts left each issue cycle so the current group always sits in the top bytes
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        kd_d    = kd_q;
        pv_d    = 1'b0;
        src_d   = src_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    src_d   = in_data;
                    k_d     = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pv_d  = 1'b1;
                kd_d  = k_q;
                src_d = src_q << SRC_SHIFT;
                if (k_q == IDX_W'(N - 1)) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            kd_q        <= '0;
            pv_q        <= 1'b0;
            src_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            kd_q        <= kd_d;
            pv_q        <= pv_d;
            src_q       <= src_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        inv_sbox u_inv_sbox (
            .clk  (clk),
            .addr (src_q[AES_STATE_W-1-AES_BYTE_W*j -: AES_BYTE_W]),
            .dout (rom_dout[AES_BYTE_W*j +: AES_BYTE_W])
        );
    end

    // Result byte b is owned by lane b%LANES and written when the delayed index matches its group
    for (genvar b = 0; b < AES_NB_BYTES; b++) begin : g_res
        localparam int unsigned LANE = b % LANES;
        localparam int unsigned GRP  = b / LANES;

        logic [AES_BYTE_W-1:0] byte_q, byte_d;

        always_comb begin
            byte_d = byte_q;
            if (pv_q && (kd_q == IDX_W'(GRP))) begin
                byte_d = rom_dout[AES_BYTE_W*LANE +: AES_BYTE_W];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) byte_q <= '0;
            else     byte_q <= byte_d;
        end

        assign out_data[AES_STATE_W-1-AES_BYTE_W*b -: AES_BYTE_W] = byte_q;
    end

`ifdef INV_SUBBYTES_SEQ_STATS_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (out_valid_q && out_ready) blk_cnt_d = blk_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) blk_cnt_q <= '0;
        else     blk_cnt_q <= blk_cnt_d;
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Scoreboard bench for inv_subbytes_seq (LANES=4 main instance plus LANES=1/2/8/16 sweep instances).
module tb_inv_subbytes_seq;
    import aes_pkg::*;

    localparam logic [127:0] V_ZERO  = 128'h0;
    localparam logic [127:0] V_52    = {16{8'h52}};
    localparam logic [127:0] V_48    = {16{8'h48}};
    localparam logic [127:0] V_16    = {16{8'h16}};
    localparam logic [127:0] V_FF    = {16{8'hff}};
    localparam logic [127:0] V_SB    = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] V_SB_IN = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data   = '0;
    logic         in_ready, out_valid;
    logic [127:0] out_data;
`ifdef INV_SUBBYTES_SEQ_STATS_EN
    logic [31:0]  blk_cnt;
`endif

    logic         sw_iv = 1'b0;
    logic         sw_or = 1'b1;
    logic [127:0] sw_in = '0;
    logic [3:0]   sw_ir, sw_ov;
    logic [127:0] sw_od [4];
`ifdef INV_SUBBYTES_SEQ_STATS_EN
    logic [31:0]  sw_cnt [4];
`endif

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    logic [127:0] exp_q [$];

    inv_subbytes_seq #(.LANES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef INV_SUBBYTES_SEQ_STATS_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        inv_subbytes_seq #(.LANES(L)) u_sw (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sw_iv),
            .in_ready  (sw_ir[g]),
            .in_data   (sw_in),
            .out_valid (sw_ov[g]),
            .out_ready (sw_or),
            .out_data  (sw_od[g])
`ifdef INV_SUBBYTES_SEQ_STATS_EN
            ,
            .blk_cnt   (sw_cnt[g])
`endif
        );
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake pops the oldest expected block
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hs_cnt = 0;
            end else if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    chk("scoreboard_unexpected_output", out_data, 128'hx);
                end else begin
                    chk("scoreboard_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    // Issue one block from IDLE with out_ready high and measure the out_valid latency
    task automatic run_block(input logic [127:0] d, input logic [127:0] e, input int lat_exp, input string nm);
        int  lat;
        bit  found;
        in_data  = d;
        in_valid = 1'b1;
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        lat   = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            lat++;
            @(negedge clk);
            if (out_valid) found = 1'b1;
            else @(posedge clk);
        end
        chk(nm, 128'(lat), 128'(lat_exp));
        tick();
    endtask

    initial begin
        logic [127:0] b2b_in  [3];
        logic [127:0] b2b_out [3];
        int           acc [3];
        int           n, t;
        int           lat_seen [4];
        int           sw_lat_exp [4];

        b2b_in  = '{V_ZERO, V_SB, V_52};
        b2b_out = '{V_52, V_SB_IN, V_48};
        sw_lat_exp = '{18, 10, 4, 3};

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, V_ZERO);
`ifdef INV_SUBBYTES_SEQ_STATS_EN
        chk("rst_blk_cnt", 128'(blk_cnt), 128'(0));
`endif
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Single blocks: zero state and the forward S-box image of 00..0f
        run_block(V_ZERO, V_52, 6, "lat_zero");
        run_block(V_SB, V_SB_IN, 6, "lat_sbox_vec");

        // Back-pressure: DONE must hold with stable data
        out_ready = 1'b0;
        in_data   = V_52;
        in_valid  = 1'b1;
        exp_q.push_back(V_48);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        chk("bp_valid_rise", 128'(out_valid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid_hold", 128'(out_valid), 128'(1));
            chk("bp_data_hold", out_data, V_48);
            chk("bp_in_ready_low", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        chk("bp_release_out_valid", 128'(out_valid), 128'(0));

        // Back-to-back with in_valid held high and garbage in_data while busy
        in_valid = 1'b1;
        n = 0;
        t = 0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            if (in_ready) begin
                in_data = b2b_in[n];
                exp_q.push_back(b2b_out[n]);
                acc[n] = t;
                n++;
            end else begin
                in_data = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            t++;
            if (n == 3) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 128'(n), 128'(3));
        if (n == 3) begin
            chk("b2b_period_1", 128'(acc[1] - acc[0]), 128'(7));
            chk("b2b_period_2", 128'(acc[2] - acc[1]), 128'(7));
        end
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        chk("b2b_drain", 128'(exp_q.size()), 128'(0));

        // Reset while issuing group k=2; in-flight ROM results must be discarded
        in_data  = V_SB;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_out_data", out_data, V_ZERO);
`ifdef INV_SUBBYTES_SEQ_STATS_EN
        chk("abort_blk_cnt", 128'(blk_cnt), 128'(0));
`endif
        tick();
        chk("abort_no_stale_write", out_data, V_ZERO);
        chk("abort_out_valid_2", 128'(out_valid), 128'(0));
        run_block(V_16, V_FF, 6, "lat_after_abort");
`ifdef INV_SUBBYTES_SEQ_STATS_EN
        chk("stats_blk_cnt", 128'(blk_cnt), 128'(hs_cnt));
        chk("stats_blk_cnt_abs", 128'(blk_cnt), 128'(1));
`endif

        // LANES sweep: same vector through 1, 2, 8 and 16 lanes
        sw_in = V_SB;
        sw_iv = 1'b1;
        tick();
        sw_iv = 1'b0;
        lat_seen = '{0, 0, 0, 0};
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (sw_ov[g] && lat_seen[g] == 0) begin
                    lat_seen[g] = c;
                    chk("sweep_data", sw_od[g], V_SB_IN);
                end
            end
            @(posedge clk);
            #1;
        end
        for (int g = 0; g < 4; g++) begin
            chk("sweep_latency", 128'(lat_seen[g]), 128'(sw_lat_exp[g]));
            chk("sweep_in_ready", 128'(sw_ir[g]), 128'(1));
`ifdef INV_SUBBYTES_SEQ_STATS_EN
            chk("sweep_blk_cnt", 128'(sw_cnt[g]), 128'(1));
`endif
        end

        chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
